// File: rtl/cv32e40p_tmr_health_voter_pkg.sv
// Shared types and default tuning constants for the TMR health voter.
// The replica health FSM and the voter top both import this package.
package cv32e40p_pkg2_ft;

    typedef enum logic [1:0] {
        HEALTHY   = 2'd0,
        BROKEN    = 2'd1,
        PROBATION = 2'd2
    } health_state_e;

    localparam int unsigned DEF_INCREMENT          = 4;
    localparam int unsigned DEF_DECREMENT          = 1;
    localparam int unsigned DEF_BREAKING_THRESHOLD = 12;
    localparam int unsigned DEF_COUNT_BIT          = 4;
    localparam int unsigned DEF_PROBATION_LEN      = 8;

endpackage

// File: rtl/cv32e40p_replica_health_fsm.sv
// Health tracking for one replica: a leaky error counter, a probation window
// for software-driven reintegration, and the HEALTHY/BROKEN/PROBATION state.
module cv32e40p_replica_health_fsm
    import cv32e40p_pkg2_ft::*;
#(
    parameter int unsigned INCREMENT          = DEF_INCREMENT,
    parameter int unsigned DECREMENT          = DEF_DECREMENT,
    parameter int unsigned BREAKING_THRESHOLD = DEF_BREAKING_THRESHOLD,
    parameter int unsigned COUNT_BIT          = DEF_COUNT_BIT,
    parameter int unsigned PROBATION_LEN      = DEF_PROBATION_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic err_i,
    input  logic judge_en_i,
    input  logic set_broken_i,
    input  logic repair_i,
    output logic is_healthy_o,
    output logic is_broken_o,
    output logic in_probation_o
);

    localparam int unsigned PW = $clog2(PROBATION_LEN + 1);
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << COUNT_BIT) - 64'd1);

    health_state_e        state_reg, state_next;
    logic [COUNT_BIT-1:0] cnt_reg, cnt_next;
    logic [PW-1:0]        pcnt_reg, pcnt_next;
    logic [31:0]          cnt_calc;
    logic                 error;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= HEALTHY;
            cnt_reg   <= '0;
            pcnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            pcnt_reg  <= pcnt_next;
        end
    end

    // An unjudged cycle counts as clean so probation can always make progress.
    always_comb begin
        error      = err_i & judge_en_i;
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pcnt_next  = pcnt_reg;
        cnt_calc   = 32'(cnt_reg);
        if (set_broken_i) begin
            state_next = BROKEN;
        end else begin
            case (state_reg)
                HEALTHY: begin
                    if (error) begin
                        cnt_calc = 32'(cnt_reg) + INCREMENT;
                        if (cnt_calc > CNT_MAX) cnt_calc = CNT_MAX;
                    end else if (32'(cnt_reg) >= DECREMENT) begin
                        cnt_calc = 32'(cnt_reg) - DECREMENT;
                    end else begin
                        cnt_calc = 32'd0;
                    end
                    cnt_next = cnt_calc[COUNT_BIT-1:0];
                    if (cnt_calc >= BREAKING_THRESHOLD) state_next = BROKEN;
                end
                BROKEN: begin
                    if (repair_i) begin
                        state_next = PROBATION;
                        cnt_next   = '0;
                        pcnt_next  = '0;
                    end
                end
                PROBATION: begin
                    if (error) begin
                        state_next = BROKEN;
                    end else if (pcnt_reg == PW'(PROBATION_LEN - 1)) begin
                        state_next = HEALTHY;
                        cnt_next   = '0;
                        pcnt_next  = '0;
                    end else begin
                        pcnt_next = pcnt_reg + 1'b1;
                    end
                end
                default: state_next = HEALTHY;
            endcase
        end
    end

    assign is_healthy_o   = (state_reg == HEALTHY);
    assign is_broken_o    = (state_reg == BROKEN);
    assign in_probation_o = (state_reg == PROBATION);

endmodule

// File: rtl/cv32e40p_tmr_health_voter.sv
// Votes a triplicated bus over the currently healthy replicas, judges every
// non-broken replica against the result and counts error cycles.
module cv32e40p_tmr_health_voter
    import cv32e40p_pkg2_ft::*;
#(
    parameter int unsigned W                  = 32,
    parameter int unsigned INCREMENT          = DEF_INCREMENT,
    parameter int unsigned DECREMENT          = DEF_DECREMENT,
    parameter int unsigned BREAKING_THRESHOLD = DEF_BREAKING_THRESHOLD,
    parameter int unsigned COUNT_BIT          = DEF_COUNT_BIT,
    parameter int unsigned PROBATION_LEN      = DEF_PROBATION_LEN,
    parameter int unsigned EVT_W              = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3*W-1:0]   to_vote_i,
    output logic [W-1:0]     voted_o,
    input  logic [2:0]       set_broken_i,
    input  logic [2:0]       repair_i,
    input  logic             clr_evt_i,
    output logic [2:0]       is_broken_o,
    output logic [2:0]       in_probation_o,
    output logic             err_detected_o,
    output logic             err_corrected_o,
    output logic             fatal_o,
    output logic [EVT_W-1:0] evt_count_o
);

    logic [W-1:0] rep [3];
    logic [2:0]   healthy;
    logic [2:0]   block_err;
    logic [2:0]   judge_en;

    always_comb begin
        voted_o         = rep[0];
        err_detected_o  = 1'b0;
        fatal_o         = 1'b0;
        case (healthy)
            3'b111: begin
                voted_o        = (rep[0] & rep[1]) | (rep[0] & rep[2]) | (rep[1] & rep[2]);
                err_detected_o = (rep[0] != rep[1]) || (rep[0] != rep[2]);
            end
            3'b011: begin
                voted_o        = rep[0];
                err_detected_o = (rep[0] != rep[1]);
                fatal_o        = err_detected_o;
            end
            3'b101: begin
                voted_o        = rep[0];
                err_detected_o = (rep[0] != rep[2]);
                fatal_o        = err_detected_o;
            end
            3'b110: begin
                voted_o        = rep[1];
                err_detected_o = (rep[1] != rep[2]);
                fatal_o        = err_detected_o;
            end
            3'b001:  voted_o = rep[0];
            3'b010:  voted_o = rep[1];
            3'b100:  voted_o = rep[2];
            default: fatal_o = 1'b1;
        endcase
        err_corrected_o = err_detected_o && (healthy == 3'b111);
    end

    // A disagreeing pair cannot tell who is wrong, so both voters take the error.
    for (genvar gi = 0; gi < 3; gi++) begin : g_replica
        logic in_prob;

        assign rep[gi]       = to_vote_i[gi*W +: W];
        assign block_err[gi] = healthy[gi]
                             ? ((healthy == 3'b111) ? (rep[gi] != voted_o) : err_detected_o)
                             : (rep[gi] != voted_o);
        assign judge_en[gi]  = healthy[gi] | (in_prob & ~fatal_o);
        assign in_probation_o[gi] = in_prob;

        cv32e40p_replica_health_fsm #(
            .INCREMENT          (INCREMENT),
            .DECREMENT          (DECREMENT),
            .BREAKING_THRESHOLD (BREAKING_THRESHOLD),
            .COUNT_BIT          (COUNT_BIT),
            .PROBATION_LEN      (PROBATION_LEN)
        ) u_fsm (
            .clk            (clk),
            .rst            (rst),
            .err_i          (block_err[gi]),
            .judge_en_i     (judge_en[gi]),
            .set_broken_i   (set_broken_i[gi]),
            .repair_i       (repair_i[gi]),
            .is_healthy_o   (healthy[gi]),
            .is_broken_o    (is_broken_o[gi]),
            .in_probation_o (in_prob)
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_count_o <= '0;
        end else if (clr_evt_i) begin
            evt_count_o <= '0;
        end else if (err_detected_o && (evt_count_o != {EVT_W{1'b1}})) begin
            evt_count_o <= evt_count_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_cv32e40p_tmr_health_voter.sv
// Directed bench for the TMR health voter; a second instance with a 2-bit
// event counter shares the stimulus to exercise saturation.
module tb_cv32e40p_tmr_health_voter;

    localparam int W = 32;
    localparam logic [31:0] A  = 32'hA5A5A5A5;
    localparam logic [31:0] AE = 32'hA5A5A5A4;

    logic          clk = 1'b0;
    logic          rst;
    logic [3*W-1:0] tv;
    logic [2:0]    set_broken, repair;
    logic          clr;

    logic [W-1:0]  voted, voted_s;
    logic [2:0]    is_broken, in_prob, is_broken_s, in_prob_s;
    logic          det, corr, fatal, det_s, corr_s, fatal_s;
    logic [15:0]   evt;
    logic [1:0]    evt_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cv32e40p_tmr_health_voter #(.W(W)) dut (
        .clk(clk), .rst(rst), .to_vote_i(tv), .voted_o(voted),
        .set_broken_i(set_broken), .repair_i(repair), .clr_evt_i(clr),
        .is_broken_o(is_broken), .in_probation_o(in_prob),
        .err_detected_o(det), .err_corrected_o(corr), .fatal_o(fatal),
        .evt_count_o(evt)
    );

    cv32e40p_tmr_health_voter #(.W(W), .EVT_W(2)) dut_s (
        .clk(clk), .rst(rst), .to_vote_i(tv), .voted_o(voted_s),
        .set_broken_i(set_broken), .repair_i(repair), .clr_evt_i(clr),
        .is_broken_o(is_broken_s), .in_probation_o(in_prob_s),
        .err_detected_o(det_s), .err_corrected_o(corr_s), .fatal_o(fatal_s),
        .evt_count_o(evt_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic setv(input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2);
        tv = {r2, r1, r0};
    endtask

    initial begin
        rst = 1'b1; tv = '0; set_broken = '0; repair = '0; clr = 1'b0;
        #12;
        chk("rst_broken", 32'(is_broken), 32'd0);
        chk("rst_prob", 32'(in_prob), 32'd0);
        chk("rst_evt", 32'(evt), 32'd0);
        rst = 1'b0;
        tick;

        // transient decay on replica 2
        setv(A, A, AE); #2;
        chk("decay_voted", voted, A);
        chk("decay_det", 32'(det), 32'd1);
        chk("decay_corr", 32'(corr), 32'd1);
        tick;
        setv(A, A, A);
        for (int k = 0; k < 4; k++) begin
            #2 chk("decay_clean_det", 32'(det), 32'd0);
            tick;
            chk("decay_not_broken", 32'(is_broken), 32'd0);
        end
        chk("decay_evt", 32'(evt), 32'd1);

        // single faulty replica 1
        setv(A, AE, A);
        for (int k = 1; k <= 3; k++) begin
            #2;
            chk("fault_voted", voted, A);
            chk("fault_corr", 32'(corr), 32'd1);
            tick;
            chk("fault_broken", 32'(is_broken), (k == 3) ? 32'd2 : 32'd0);
        end
        chk("fault_evt", 32'(evt), 32'd4);
        chk("sat_evt", 32'(evt_s), 32'd3);

        // reintegration of replica 1
        setv(A, A, A); repair = 3'b010; #2;
        chk("reint_pre_prob", 32'(in_prob), 32'd0);
        tick; repair = 3'b000;
        for (int k = 0; k < 8; k++) begin
            chk("reint_prob", 32'(in_prob), 32'd2);
            tick;
        end
        chk("reint_done_prob", 32'(in_prob), 32'd0);
        chk("reint_done_broken", 32'(is_broken), 32'd0);

        // degraded 2-of-2 with disagreement
        set_broken = 3'b001; tick; set_broken = 3'b000;
        chk("deg_broken", 32'(is_broken), 32'd1);
        setv(32'h0, 32'h1111_1111, 32'h2222_2222); #2;
        chk("deg_voted", voted, 32'h1111_1111);
        chk("deg_det", 32'(det), 32'd1);
        chk("deg_corr", 32'(corr), 32'd0);
        chk("deg_fatal", 32'(fatal), 32'd1);
        tick;
        chk("deg_evt", 32'(evt), 32'd5);

        // probation failure at cycle 5 on replica 0
        setv(A, A, A); repair = 3'b001; tick; repair = 3'b000;
        chk("pfail_prob", 32'(in_prob), 32'd1);
        repeat (4) tick;
        chk("pfail_still_prob", 32'(in_prob), 32'd1);
        setv(AE, A, A); #2;
        chk("pfail_voted", voted, A);
        chk("pfail_det", 32'(det), 32'd0);
        tick;
        chk("pfail_broken", 32'(is_broken), 32'd1);
        chk("pfail_out", 32'(in_prob), 32'd0);
        chk("pfail_evt", 32'(evt), 32'd5);

        // set_broken wins over repair
        setv(A, A, A); set_broken = 3'b001; repair = 3'b001; tick;
        set_broken = 3'b000; repair = 3'b000;
        chk("coll_broken", 32'(is_broken), 32'd1);
        chk("coll_prob", 32'(in_prob), 32'd0);

        // all broken, then joint repair
        set_broken = 3'b111; tick; set_broken = 3'b000;
        chk("all_broken", 32'(is_broken), 32'd7);
        setv(32'h0000_1234, 32'h5, 32'h6); #2;
        chk("none_voted", voted, 32'h0000_1234);
        chk("none_fatal", 32'(fatal), 32'd1);
        chk("none_det", 32'(det), 32'd0);
        setv(A, A, A); repair = 3'b111; tick; repair = 3'b000;
        chk("all_prob", 32'(in_prob), 32'd7);
        for (int k = 0; k < 7; k++) begin
            #2 chk("all_prob_fatal", 32'(fatal), 32'd1);
            tick;
        end
        chk("all_prob_last", 32'(in_prob), 32'd7);
        tick;
        chk("all_healthy_prob", 32'(in_prob), 32'd0);
        chk("all_healthy_broken", 32'(is_broken), 32'd0);
        #2 chk("all_healthy_fatal", 32'(fatal), 32'd0);

        // clear wins over a simultaneous error
        setv(A, AE, A); clr = 1'b1; #2;
        chk("clr_det", 32'(det), 32'd1);
        tick; clr = 1'b0;
        chk("clr_evt", 32'(evt), 32'd0);
        chk("clr_evt_s", 32'(evt_s), 32'd0);
        setv(A, A, A); tick;
        setv(AE, A, A); tick;
        chk("post_clr_evt", 32'(evt), 32'd1);

        // asynchronous reset in the middle of probation
        setv(A, A, A); set_broken = 3'b100; tick; set_broken = 3'b000;
        repair = 3'b100; tick; repair = 3'b000;
        tick; tick;
        chk("arst_pre_prob", 32'(in_prob), 32'd4);
        #3 rst = 1'b1;
        #1;
        chk("arst_prob", 32'(in_prob), 32'd0);
        chk("arst_broken", 32'(is_broken), 32'd0);
        chk("arst_evt", 32'(evt), 32'd0);
        #3 rst = 1'b0;
        tick;
        setv(A, A, AE); #2;
        chk("arst_after_voted", voted, A);
        chk("arst_after_corr", 32'(corr), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
